// File: rtl/fast_pkg.sv
// Shared definitions for the FAST segment-test block and the circle overlay drawer.
// Contents: the 12-point radius-2 ring offsets, the ring size, the fetch index
// range and the segment-test FSM state encoding.
package fast_pkg;

  localparam int RING_N = 12;
  localparam int IDX_W  = 4;

  // Read index 0 is the center; indices 1..12 walk the ring.
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd12;

  typedef logic signed [2:0] ofs_t;

  // Ring point k sits at (center_x + RING_DX[k], center_y + RING_DY[k]).
  localparam ofs_t RING_DX [RING_N] = '{3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd2, 3'sd1,
                                        3'sd0, -3'sd1, -3'sd2, -3'sd2, -3'sd2, -3'sd1};
  localparam ofs_t RING_DY [RING_N] = '{3'sd2, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2,
                                        -3'sd2, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    WRITE = 3'd4
  } fast_state_t;

endpackage

// File: rtl/arc_detect.sv
// Circular run detector for the 12-point ring.
// Ports:
//   mask  in  RING_N  per-ring-point classification (1 = point qualifies)
//   n_arc in  4       minimum contiguous run length (1..12)
//   hit   out 1       1 when some run of n_arc set bits exists, wrapping 11 -> 0
module arc_detect
  import fast_pkg::*;
(
  input  logic [RING_N-1:0] mask,
  input  logic [3:0]        n_arc,
  output logic              hit
);

  logic [2*RING_N-1:0] dbl_s;
  logic [RING_N-1:0]   need_s;
  logic [RING_N-1:0]   win_s;

  // Slide an n_arc-wide window over the doubled mask so wrap-around runs are seen.
  always_comb begin
    dbl_s  = {mask, mask};
    need_s = RING_N'((13'd1 << n_arc) - 13'd1);
    win_s  = {RING_N{1'b0}};
    hit    = 1'b0;
    for (int s = 0; s < RING_N; s++) begin
      win_s = RING_N'(dbl_s >> s);
      if ((win_s & need_s) == need_s) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/fast_ring_test.sv
// FAST corner segment test for one candidate pixel.
// Fetches the center and its 12 ring pixels from the image SRAM (1-cycle read
// latency), classifies the ring as brighter/darker than center +/- THRESH and
// writes a corner flag to the flag SRAM. Border candidates skip the fetch.
// Ports:
//   clk, n_rst                 clock, async active-low reset
//   curr_x, curr_y, start      candidate pixel and single-cycle start pulse
//   pixel_in                   image SRAM read data
//   read_SRAM_img, x/y_addr_img    image read strobe and address
//   write_SRAM_fast, x/y_addr_fast, fast_flag   flag write strobe, address, data
//   update_pos                 pulse to advance to the next candidate
//   busy                       high whenever the FSM is not idle
// All outputs are registered: they are computed from the next state.
module fast_ring_test
  import fast_pkg::*;
#(
  parameter int X_MAX  = 10,
  parameter int Y_MAX  = 10,
  parameter int THRESH = 20,
  parameter int N_ARC  = 9
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic signed [$clog2(X_MAX):0] curr_x,
  input  logic signed [$clog2(X_MAX):0] curr_y,
  input  logic                         start,
  input  logic [7:0]                   pixel_in,
  output logic                         read_SRAM_img,
  output logic signed [$clog2(X_MAX):0] x_addr_img,
  output logic signed [$clog2(X_MAX):0] y_addr_img,
  output logic                         write_SRAM_fast,
  output logic signed [$clog2(X_MAX):0] x_addr_fast,
  output logic signed [$clog2(X_MAX):0] y_addr_fast,
  output logic                         fast_flag,
  output logic                         update_pos,
  output logic                         busy
);

  localparam int AW = $clog2(X_MAX) + 1;
  localparam logic signed [AW-1:0] EDGE_LO = AW'(2);
  localparam logic signed [AW-1:0] X_HI    = AW'(X_MAX - 3);
  localparam logic signed [AW-1:0] Y_HI    = AW'(Y_MAX - 3);
  localparam logic signed [9:0]    TH      = 10'(THRESH);

  // Ring offsets are sign-extended before being added to the center.
  function automatic logic signed [AW-1:0] add_ofs(input logic signed [AW-1:0] c,
                                                   input ofs_t o);
    add_ofs = c + AW'(o);
  endfunction

  fast_state_t             state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic signed [AW-1:0]    cx_r, cx_s, cy_r, cy_s;
  logic                    result_r, result_s;
  logic [7:0]              pix_r [RING_N+1];
  logic                    cap_valid_r;
  logic [IDX_W-1:0]        cap_idx_r;
  logic [RING_N-1:0]       bright_s, dark_s;
  logic                    hit_b_s, hit_d_s;
  logic signed [9:0]       c10_s, p10_s;
  logic                    rd_s, wr_s, flag_s;
  logic signed [AW-1:0]    xa_s, ya_s, xf_s, yf_s;

  // Classify each ring pixel against the center in 10-bit signed arithmetic.
  always_comb begin
    c10_s = signed'({2'b00, pix_r[0]});
    p10_s = 10'sd0;
    for (int k = 0; k < RING_N; k++) begin
      p10_s       = signed'({2'b00, pix_r[k+1]});
      bright_s[k] = (p10_s > (c10_s + TH));
      dark_s[k]   = (p10_s < (c10_s - TH));
    end
  end

  arc_detect u_arc_bright (.mask(bright_s), .n_arc(4'(N_ARC)), .hit(hit_b_s));
  arc_detect u_arc_dark   (.mask(dark_s),   .n_arc(4'(N_ARC)), .hit(hit_d_s));

  // Next-state logic: candidate latch, fetch index walk and result capture.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    cx_s     = cx_r;
    cy_s     = cy_r;
    result_s = result_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          cx_s = curr_x;
          cy_s = curr_y;
          if ((curr_x < EDGE_LO) || (curr_x > X_HI) ||
              (curr_y < EDGE_LO) || (curr_y > Y_HI)) begin
            state_s  = WRITE;
            result_s = 1'b0;
          end else begin
            state_s = FETCH;
            idx_s   = 4'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (idx_r == LAST_IDX) begin
          state_s = DRAIN;
        end else begin
          idx_s = idx_r + 4'd1;
        end
      end
      DRAIN: state_s = EVAL;
      EVAL: begin
        result_s = hit_b_s | hit_d_s;
        state_s  = WRITE;
      end
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the cycle that the next state will occupy.
  always_comb begin
    rd_s   = (state_s == FETCH);
    wr_s   = (state_s == WRITE);
    xa_s   = {AW{1'b0}};
    ya_s   = {AW{1'b0}};
    xf_s   = {AW{1'b0}};
    yf_s   = {AW{1'b0}};
    flag_s = 1'b0;
    if (rd_s) begin
      if (idx_s == 4'd0) begin
        xa_s = cx_s;
        ya_s = cy_s;
      end else begin
        xa_s = add_ofs(cx_s, RING_DX[idx_s - 4'd1]);
        ya_s = add_ofs(cy_s, RING_DY[idx_s - 4'd1]);
      end
    end else begin
      xa_s = {AW{1'b0}};
      ya_s = {AW{1'b0}};
    end
    if (wr_s) begin
      xf_s   = cx_s;
      yf_s   = cy_s;
      flag_s = result_s;
    end else begin
      flag_s = 1'b0;
    end
  end

  // State, candidate, result and registered output update.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r         <= IDLE;
      idx_r           <= 4'd0;
      cx_r            <= {AW{1'b0}};
      cy_r            <= {AW{1'b0}};
      result_r        <= 1'b0;
      read_SRAM_img   <= 1'b0;
      x_addr_img      <= {AW{1'b0}};
      y_addr_img      <= {AW{1'b0}};
      write_SRAM_fast <= 1'b0;
      x_addr_fast     <= {AW{1'b0}};
      y_addr_fast     <= {AW{1'b0}};
      fast_flag       <= 1'b0;
      update_pos      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_r         <= state_s;
      idx_r           <= idx_s;
      cx_r            <= cx_s;
      cy_r            <= cy_s;
      result_r        <= result_s;
      read_SRAM_img   <= rd_s;
      x_addr_img      <= xa_s;
      y_addr_img      <= ya_s;
      write_SRAM_fast <= wr_s;
      x_addr_fast     <= xf_s;
      y_addr_fast     <= yf_s;
      fast_flag       <= flag_s;
      update_pos      <= wr_s;
      busy            <= (state_s != IDLE);
    end
  end

  // Read data returns one cycle after its address: capture it into its slot then.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cap_valid_r <= 1'b0;
      cap_idx_r   <= 4'd0;
      for (int i = 0; i <= RING_N; i++) begin
        pix_r[i] <= 8'd0;
      end
    end else begin
      cap_valid_r <= (state_r == FETCH);
      cap_idx_r   <= idx_r;
      if (cap_valid_r) begin
        pix_r[cap_idx_r] <= pixel_in;
      end
    end
  end

endmodule

// File: doc/fast_ring_test.md
FAST_RING_TEST -- requirements
Module: fast_ring_test

Interface
REQ-001 SHALL have parameter X_MAX, default 10, meaning image width in pixels (valid x 0..X_MAX-1).
REQ-002 SHALL have parameter Y_MAX, default 10, meaning image height in pixels (valid y 0..Y_MAX-1).
REQ-003 SHALL have parameter THRESH, default 20, meaning the intensity margin for the segment test.
REQ-004 SHALL have parameter N_ARC, default 9, meaning the minimum contiguous ring run for a corner (range 1..12).
REQ-005 SHALL provide ports, in this order:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- curr_x, curr_y  in  signed [$clog2(X_MAX):0]  candidate pixel.
- start  in  1  begin test (single-cycle pulse).
- pixel_in  in  8  grayscale image SRAM read data.
- read_SRAM_img  out  1  image read strobe.
- x_addr_img, y_addr_img  out  signed [$clog2(X_MAX):0]  image read address.
- write_SRAM_fast  out  1  flag write strobe.
- x_addr_fast, y_addr_fast  out  signed [$clog2(X_MAX):0]  flag write address.
- fast_flag  out  1  flag write data (1 = corner).
- update_pos  out  1  one-cycle pulse: advance to next pixel.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-006 Ring SHALL be the 12-point radius-2 circle, index k=0..11: dx={0,1,2,2,2,1,0,-1,-2,-2,-2,-1}, dy={2,2,1,0,-1,-2,-2,-2,-1,0,1,2}. This is the same table used by the circle overlay drawer.
REQ-007 FSM states SHALL be IDLE, FETCH, DRAIN, EVAL, WRITE.
REQ-008 IDLE: on start, latch curr_x/curr_y.
- If the candidate is on the border (x<2, x>X_MAX-3, y<2 or y>Y_MAX-3), go to WRITE with result 0.
- Otherwise go to FETCH with a read index of 0.
REQ-009 start SHALL be ignored outside IDLE.
REQ-010 FETCH SHALL last 13 cycles, asserting read_SRAM_img with read index i=0..12:
- i=0 addresses the center.
- i=1..12 address latched center + (dx[i-1], dy[i-1]).
- FETCH then goes to DRAIN.
REQ-011 Image SRAM read latency SHALL be 1 cycle: pixel_in for read index i is captured on the cycle after its address. DRAIN captures i=12 and goes to EVAL.
REQ-012 EVAL SHALL classify each ring pixel p against center c, in 10-bit signed arithmetic (no wrap/overflow):
- brighter if p > c+THRESH;
- darker if p < c-THRESH;
- equality is neither.
REQ-013 EVAL SHALL set result=1 iff there is a circular run (wrapping index 11→0) of at least N_ARC consecutive brighter pixels, or of at least N_ARC consecutive darker pixels. Mixed runs do not count. EVAL then goes to WRITE.
REQ-014 WRITE SHALL last one cycle, then return to IDLE. In that cycle it asserts:
- write_SRAM_fast=1, fast_flag=result, x/y_addr_fast = latched center;
- update_pos=1.
REQ-015 Outside their active states, read_SRAM_img, write_SRAM_fast, fast_flag and update_pos SHALL be 0, and all address outputs SHALL be 0.
REQ-016 Latency with start at cycle T:
- interior: reads at T+1..T+13, WRITE/update_pos at T+16;
- border: WRITE/update_pos at T+1 with no image reads.

Reset
REQ-017 n_rst low SHALL asynchronously force IDLE and clear latched coordinates, captured pixels and result.
REQ-018 While in reset, all outputs SHALL be 0.
REQ-019 Reset mid-operation SHALL abort with no flag write and no update_pos.

Structure
REQ-020 The dx/dy ring tables, ring size 12 and the state enum SHALL live in shared package fast_pkg, for reuse by the circle drawer.
REQ-021 The circular-run detector (12-bit mask and N_ARC in, hit out) SHALL be a combinational sub-module arc_detect, instantiated twice (brighter, darker).

Verification
REQ-022 The bench SHALL use X_MAX=Y_MAX=10, THRESH=20, N_ARC=9 and a 1-cycle SRAM model, and SHALL cover these directed scenarios:
- Uniform image of 100, start at (5,5): 13 reads, then write_SRAM_fast at T+16 with fast_flag=0 at (5,5); update_pos at T+16.
- Center 50, all ring pixels 200: fast_flag=1.
- Center 100, ring k=8..11 and 0..4 =150, rest 100: flag=1 (wrap run of 9). Same with k=4 set back to 100: flag=0 (run of 8).
- Center 100, ring all 120: flag=0 (equality). Ring all 121: flag=1. Ring all 79: flag=1 (darker).
- Start at (1,5): no read_SRAM_img; write flag 0 and update_pos at T+1.
- n_rst pulsed during FETCH: all outputs 0, no write; start pulsed while busy: ignored, exactly one WRITE per accepted start.
